// File: rtl/ahb_crypto_dma_master.sv
// AHB-Lite initiator streaming 32-bit words to/from the crypto accelerator windows.
// Single-beat NONSEQ transfers, fully pipelined: one word per cycle at zero wait states.
module ahb_crypto_dma_master #(
    parameter int unsigned LEN_W     = 8,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic             hclk,
    input  logic             hrst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_write,
    input  logic [31:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             err,
    output logic [31:0]      haddr,
    output logic [1:0]       htrans,
    output logic             hwrite,
    output logic [2:0]       hsize,
    output logic [2:0]       hburst,
    output logic [3:0]       hprot,
    output logic [31:0]      hwdata,
    input  logic [31:0]      hrdata,
    input  logic             hready,
    input  logic [1:0]       hresp
);
    typedef enum logic [1:0] {StIdle, StXfer, StErr} state_t;

    state_t             state_q, state_d;
    logic               run_q;
    logic [31:0]        addr_q, addr_d;
    logic [LEN_W-1:0]   issue_q, issue_d;
    logic [LEN_W-1:0]   data_q, data_d;
    logic               dir_q, dir_d;
    logic               pend_q, pend_d;   // NONSEQ driven but stalled: must not be withdrawn
    logic               dph_q, dph_d;     // a data phase is outstanding
    logic [31:0]        hwdata_q, hwdata_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               resp_err, err_first, issue, accept, beat_ok;
    logic               unused_addr_lsbs;

    // Low address bits are forced to zero on latch, so they are never used.
    assign unused_addr_lsbs = ^cmd_addr[1:0];

    assign resp_err  = (hresp != 2'b00);
    // First ERROR cycle: drop any pending address phase so no further beat is launched.
    assign err_first = (state_q == StXfer) && dph_q && resp_err && !hready;
    assign issue     = (state_q == StXfer) && (issue_q != '0) &&
                       (!dir_q || wr_valid || pend_q) && !err_first;
    assign accept    = issue && hready;
    assign beat_ok   = (state_q == StXfer) && dph_q && hready && !resp_err;

    assign cmd_ready = run_q && (state_q == StIdle);
    assign wr_ready  = accept && dir_q;
    assign htrans    = issue ? 2'b10 : 2'b00;
    assign haddr     = addr_q;
    assign hwrite    = dir_q;
    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    assign hprot     = HPROT_VAL;
    assign hwdata    = hwdata_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;

    // Next-state logic for command latch, address/data phase bookkeeping and status pulses.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        issue_d    = issue_q;
        data_d     = data_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        dph_d      = dph_q;
        hwdata_d   = hwdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            StIdle: begin
                pend_d = 1'b0;
                dph_d  = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    addr_d  = {cmd_addr[31:2], 2'b00};
                    issue_d = cmd_len;
                    data_d  = cmd_len;
                    dir_d   = cmd_write;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StXfer;
                    end
                end
            end
            StXfer: begin
                if (err_first) begin
                    state_d = StErr;
                    pend_d  = 1'b0;
                end else if (dph_q && hready && resp_err) begin
                    // Single-cycle error response: abort directly.
                    state_d = StIdle;
                    err_d   = 1'b1;
                    dph_d   = 1'b0;
                    pend_d  = 1'b0;
                end else begin
                    pend_d = issue && !hready;
                    if (accept) begin
                        addr_d  = addr_q + 32'd4;
                        issue_d = issue_q - LEN_W'(1);
                        if (dir_q) begin
                            hwdata_d = wr_data;
                        end
                    end
                    dph_d = accept ? 1'b1 : (hready ? 1'b0 : dph_q);
                    if (beat_ok) begin
                        data_d = data_q - LEN_W'(1);
                        if (!dir_q) begin
                            rd_data_d  = hrdata;
                            rd_valid_d = 1'b1;
                        end
                        if (data_q == LEN_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
            end
            StErr: begin
                if (hready) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                    dph_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; run_q delays cmd_ready by one cycle after reset release.
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_q    <= StIdle;
            run_q      <= 1'b0;
            addr_q     <= '0;
            issue_q    <= '0;
            data_q     <= '0;
            dir_q      <= 1'b0;
            pend_q     <= 1'b0;
            dph_q      <= 1'b0;
            hwdata_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            addr_q     <= addr_d;
            issue_q    <= issue_d;
            data_q     <= data_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            dph_q      <= dph_d;
            hwdata_q   <= hwdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_ahb_crypto_dma_master.sv
// Self-checking bench: AHB slave + write source model, event logs, per-scenario checks.
`timescale 1ns/1ps
module tb_ahb_crypto_dma_master;
    localparam int LEN_W = 8;

    logic             hclk = 1'b0;
    logic             hrst = 1'b0;
    logic             cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0]      cmd_addr = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [31:0]      wr_data, rd_data, haddr, hwdata, hrdata;
    logic             wr_valid, wr_ready, rd_valid, done, err, hwrite, hready;
    logic [1:0]       htrans, hresp;
    logic [2:0]       hsize, hburst;
    logic [3:0]       hprot;

    always #5 hclk = ~hclk;

    ahb_crypto_dma_master #(.LEN_W(LEN_W), .HPROT_VAL(4'b0011)) dut (
        .hclk(hclk), .hrst(hrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_write(cmd_write),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    int n_checks = 0, n_fail = 0;
    // slave / source knobs
    int wait_pct = 0, gap_pct = 0, stall_beat = -1, stall_n = 0, err_beat = -1;
    logic [31:0] rmask = '0;
    bit cur_dir = 0;
    // logs
    logic [31:0] alog[$], wlog[$], rlog[$], src_q[$], exp_w[$];
    int done_log[$], err_log[$];
    int cyc = 0, acc_cyc = -1, first_ns = -1, wr_ready_cnt = 0, viol = 0, viol_err = 0;
    int rd_last_cyc = -1;
    // slave state
    bit s_pend = 0, s_write = 0, consumed = 0, err1, err2;
    logic [31:0] s_addr;
    int s_beat = 0, s_beats = 0, s_stall = 0, s_err_stage = 0;
    bit prev_stall_ns = 0, prev_dstall = 0, prev_hwrite = 0;
    logic [31:0] prev_haddr = '0, prev_hwdata = '0;

    // Slave and write source: drive at negedge, observe settled DUT outputs 1ns later.
    initial begin
        hready = 1'b1; hresp = 2'b00; hrdata = '0; wr_valid = 1'b0; wr_data = '0;
        forever begin
            @(negedge hclk);
            if (hrst) begin
                s_pend = 0; s_err_stage = 0; s_stall = 0; prev_stall_ns = 0; prev_dstall = 0;
                hready = 1'b1; hresp = 2'b00; consumed = 0; wr_valid = 1'b0;
                continue;
            end
            err1 = 0; err2 = 0; hresp = 2'b00; hready = 1'b1;
            if (s_pend) begin
                if (s_beat == err_beat) begin
                    hresp = 2'b01;
                    if (s_err_stage == 0) begin hready = 1'b0; err1 = 1; s_err_stage = 1; end
                    else begin hready = 1'b1; err2 = 1; end
                end else if (s_stall > 0) begin
                    hready = 1'b0; s_stall--;
                end else begin
                    hrdata = s_addr ^ rmask;
                end
            end
            // valid/ready source: a word once offered is held until consumed
            if (!(wr_valid && !consumed && src_q.size() > 0)) begin
                if (src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                    wr_valid = 1'b1; wr_data = src_q[0];
                end else begin
                    wr_valid = 1'b0;
                end
            end
            consumed = 0;
            #1;
            cyc++;
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (rd_valid) begin rlog.push_back(rd_data); rd_last_cyc = cyc; end
            if (done) done_log.push_back(cyc);
            if (err) err_log.push_back(cyc);
            if (htrans == 2'b10 && first_ns < 0) first_ns = cyc;
            if (wr_ready) begin
                wr_ready_cnt++;
                if (!(htrans == 2'b10 && hready && hwrite && wr_valid)) viol++;
            end
            if (wr_valid && wr_ready) begin void'(src_q.pop_front()); consumed = 1; end
            if (err1 && (htrans != 2'b00 || wr_ready)) viol_err++;
            if (err2 && htrans != 2'b00) viol_err++;
            if (prev_stall_ns && !err1 &&
                (htrans != 2'b10 || haddr != prev_haddr || hwrite != prev_hwrite)) viol++;
            if (htrans == 2'b10 && hwrite && !wr_valid && !prev_stall_ns) viol++;
            if (htrans == 2'b10 && hwrite != cur_dir) viol++;
            if (prev_dstall && s_pend && s_write && hwdata != prev_hwdata) viol++;
            prev_stall_ns = (htrans == 2'b10) && !hready;
            prev_dstall   = s_pend && !hready;
            prev_haddr = haddr; prev_hwrite = hwrite; prev_hwdata = hwdata;
            if (s_pend && hready) begin
                if (hresp == 2'b00 && s_write) wlog.push_back(hwdata);
                s_pend = 0; s_err_stage = 0;
            end
            if (htrans == 2'b10 && hready) begin
                alog.push_back(haddr);
                s_pend = 1; s_addr = haddr; s_write = hwrite; s_beat = s_beats; s_beats++;
                s_stall = (s_beat == stall_beat) ? stall_n :
                          (($urandom_range(99) < wait_pct) ? int'($urandom_range(2, 1)) : 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic clear_logs();
        alog.delete(); wlog.delete(); rlog.delete(); done_log.delete(); err_log.delete();
        acc_cyc = -1; first_ns = -1; wr_ready_cnt = 0; viol = 0; viol_err = 0; s_beats = 0;
        rd_last_cyc = -1;
    endtask

    // Post one command and wait (bounded) for its done/err pulse.
    task automatic run_cmd(input logic [31:0] addr, input int len, input bit wr, output bit tmo);
        logic [31:0] w;
        clear_logs();
        exp_w.delete(); src_q.delete();
        cur_dir = wr;
        if (wr) for (int i = 0; i < len; i++) begin
            w = $urandom; src_q.push_back(w); exp_w.push_back(w);
        end
        @(negedge hclk);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len = LEN_W'(len); cmd_write = wr;
        tmo = 1;
        for (int i = 0; i < 50; i++) begin
            #2;
            if (acc_cyc >= 0) begin tmo = 0; break; end
            @(negedge hclk);
        end
        @(posedge hclk); #1 cmd_valid = 1'b0;
        if (!tmo) begin
            tmo = 1;
            for (int i = 0; i < 400; i++) begin
                @(negedge hclk); #2;
                if (done_log.size() + err_log.size() > 0) begin tmo = 0; break; end
            end
        end
        repeat (3) @(negedge hclk);
        #2 src_q.delete();
    endtask

    task automatic test_reset();
        hrst = 1'b0; #1 hrst = 1'b1;
        #21;
        n_checks++;
        if ({cmd_ready, wr_ready, rd_valid, done, err, htrans, hwrite, haddr, hwdata, rd_data} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want all zero",
                {cmd_ready, wr_ready, rd_valid, done, err, htrans, hwrite});
        end
        n_checks++;
        if ({hsize, hburst, hprot} !== {3'b010, 3'b000, 4'b0011}) begin
            n_fail++; $display("FAIL reset_consts: got %b want %b", {hsize, hburst, hprot},
                {3'b010, 3'b000, 4'b0011});
        end
        @(negedge hclk); #3 hrst = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_ready: got %b want 0", cmd_ready); end
        @(posedge hclk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_basic();
        bit tmo;
        logic [31:0] e;
        wait_pct = 0; gap_pct = 0; stall_beat = -1; err_beat = -1;
        run_cmd(32'h2003_0000, 4, 1'b1, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL wr_timeout: got %b want 0", tmo); end
        n_checks++; if (alog.size() !== 4) begin n_fail++; $display("FAIL wr_beats: got %0d want 4", alog.size()); end
        foreach (alog[i]) begin
            e = 32'h2003_0000 + 32'(4 * i);
            n_checks++; if (alog[i] !== e) begin n_fail++; $display("FAIL wr_addr[%0d]: got %h want %h", i, alog[i], e); end
        end
        n_checks++; if (wlog.size() !== 4) begin n_fail++; $display("FAIL wr_words: got %0d want 4", wlog.size()); end
        foreach (wlog[i]) begin
            n_checks++; if (wlog[i] !== exp_w[i]) begin n_fail++; $display("FAIL wr_data[%0d]: got %h want %h", i, wlog[i], exp_w[i]); end
        end
        n_checks++; if (done_log.size() !== 1 || err_log.size() !== 0) begin
            n_fail++; $display("FAIL wr_status: got done=%0d err=%0d want 1/0", done_log.size(), err_log.size()); end
        if (done_log.size() > 0) begin
            n_checks++; if (done_log[0] - acc_cyc !== 6) begin n_fail++; $display("FAIL wr_done_lat: got %0d want 6", done_log[0] - acc_cyc); end
        end
        n_checks++; if (first_ns - acc_cyc !== 1) begin n_fail++; $display("FAIL wr_first_ns: got %0d want 1", first_ns - acc_cyc); end
        n_checks++; if (wr_ready_cnt !== 4) begin n_fail++; $display("FAIL wr_ready_cnt: got %0d want 4", wr_ready_cnt); end
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL wr_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_read_basic();
        bit tmo;
        logic [31:0] e;
        rmask = '0;
        run_cmd(32'h2004_0010, 3, 1'b0, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL rd_timeout: got %b want 0", tmo); end
        n_checks++; if (rlog.size() !== 3) begin n_fail++; $display("FAIL rd_count: got %0d want 3", rlog.size()); end
        foreach (rlog[i]) begin
            e = 32'h2004_0010 + 32'(4 * i);
            n_checks++; if (rlog[i] !== e) begin n_fail++; $display("FAIL rd_data[%0d]: got %h want %h", i, rlog[i], e); end
        end
        n_checks++; if (done_log.size() !== 1) begin n_fail++; $display("FAIL rd_done: got %0d want 1", done_log.size()); end
        if (done_log.size() > 0) begin
            n_checks++; if (done_log[0] !== rd_last_cyc) begin n_fail++; $display("FAIL rd_done_align: got %0d want %0d", done_log[0], rd_last_cyc); end
            n_checks++; if (done_log[0] - acc_cyc !== 5) begin n_fail++; $display("FAIL rd_done_lat: got %0d want 5", done_log[0] - acc_cyc); end
        end
    endtask

    task automatic test_stall_gaps();
        bit tmo;
        stall_beat = 1; stall_n = 2; gap_pct = 50;
        run_cmd(32'h2002_0000, 4, 1'b1, tmo);
        stall_beat = -1; gap_pct = 0;
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL st_timeout: got %b want 0", tmo); end
        n_checks++; if (wlog.size() !== 4) begin n_fail++; $display("FAIL st_words: got %0d want 4", wlog.size()); end
        foreach (wlog[i]) begin
            n_checks++; if (wlog[i] !== exp_w[i]) begin n_fail++; $display("FAIL st_data[%0d]: got %h want %h", i, wlog[i], exp_w[i]); end
        end
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL st_protocol: got %0d violations want 0", viol); end
        n_checks++; if (done_log.size() !== 1) begin n_fail++; $display("FAIL st_done: got %0d want 1", done_log.size()); end
    endtask

    task automatic test_error();
        bit tmo;
        err_beat = 1;
        run_cmd(32'h2003_0040, 4, 1'b1, tmo);
        err_beat = -1;
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL er_timeout: got %b want 0", tmo); end
        n_checks++; if (alog.size() !== 2) begin n_fail++; $display("FAIL er_beats: got %0d want 2", alog.size()); end
        n_checks++; if (wr_ready_cnt !== 2) begin n_fail++; $display("FAIL er_consumed: got %0d want 2", wr_ready_cnt); end
        n_checks++; if (wlog.size() !== 1) begin n_fail++; $display("FAIL er_words: got %0d want 1", wlog.size()); end
        n_checks++; if (err_log.size() !== 1 || done_log.size() !== 0) begin
            n_fail++; $display("FAIL er_status: got err=%0d done=%0d want 1/0", err_log.size(), done_log.size()); end
        if (err_log.size() > 0) begin
            n_checks++; if (err_log[0] - acc_cyc !== 5) begin n_fail++; $display("FAIL er_lat: got %0d want 5", err_log[0] - acc_cyc); end
        end
        n_checks++; if (viol_err !== 0) begin n_fail++; $display("FAIL er_cancel: got %0d violations want 0", viol_err); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL er_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_zero_len_wrap();
        bit tmo;
        run_cmd(32'h2002_0100, 0, 1'b0, tmo);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL z_timeout: got %b want 0", tmo); end
        n_checks++; if (first_ns !== -1) begin n_fail++; $display("FAIL z_bus_quiet: got nonseq at %0d want none", first_ns); end
        if (done_log.size() > 0) begin
            n_checks++; if (done_log[0] - acc_cyc !== 1) begin n_fail++; $display("FAIL z_done_lat: got %0d want 1", done_log[0] - acc_cyc); end
        end
        n_checks++; if (done_log.size() !== 1) begin n_fail++; $display("FAIL z_done: got %0d want 1", done_log.size()); end
        rmask = '0;
        run_cmd(32'hFFFF_FFFE, 2, 1'b0, tmo);
        n_checks++; if (alog.size() !== 2) begin n_fail++; $display("FAIL wrap_beats: got %0d want 2", alog.size()); end
        if (alog.size() == 2) begin
            n_checks++; if (alog[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_a0: got %h want fffffffc", alog[0]); end
            n_checks++; if (alog[1] !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_a1: got %h want 00000000", alog[1]); end
        end
        n_checks++; if (rlog.size() !== 2) begin n_fail++; $display("FAIL wrap_rd: got %0d want 2", rlog.size()); end
    endtask

    task automatic test_reset_mid();
        bit tmo;
        logic [31:0] e;
        clear_logs(); cur_dir = 0; wait_pct = 0;
        @(negedge hclk);
        cmd_valid = 1'b1; cmd_addr = 32'h2004_0000; cmd_len = LEN_W'(4); cmd_write = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge hclk); #2;
            if (acc_cyc >= 0) cmd_valid = 1'b0;
            if (alog.size() >= 2) break;
        end
        cmd_valid = 1'b0;
        n_checks++; if (alog.size() < 2) begin n_fail++; $display("FAIL rm_progress: got %0d beats want >=2", alog.size()); end
        #1 hrst = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready, wr_ready, rd_valid, done, err, htrans, hwrite, haddr, hwdata, rd_data} !== '0) begin
            n_fail++; $display("FAIL rm_outputs: got htrans=%b haddr=%h rdv=%b want all zero", htrans, haddr, rd_valid);
        end
        repeat (2) @(negedge hclk);
        rlog.delete(); done_log.delete(); err_log.delete();
        #3 hrst = 1'b0;
        repeat (5) @(negedge hclk);
        #2;
        n_checks++; if (rlog.size() + done_log.size() + err_log.size() !== 0) begin
            n_fail++; $display("FAIL rm_quiet: got %0d pulses want 0", rlog.size() + done_log.size() + err_log.size()); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready: got %b want 1", cmd_ready); end
        rmask = 32'h5A5A_0000;
        run_cmd(32'h2002_0008, 2, 1'b0, tmo);
        n_checks++; if (rlog.size() !== 2 || done_log.size() !== 1) begin
            n_fail++; $display("FAIL rm_after: got rd=%0d done=%0d want 2/1", rlog.size(), done_log.size()); end
        foreach (rlog[i]) begin
            e = (32'h2002_0008 + 32'(4 * i)) ^ rmask;
            n_checks++; if (rlog[i] !== e) begin n_fail++; $display("FAIL rm_data[%0d]: got %h want %h", i, rlog[i], e); end
        end
    endtask

    task automatic test_random();
        bit tmo, wr;
        int len;
        logic [31:0] base, e;
        wait_pct = 30; gap_pct = 30;
        for (int k = 0; k < 10; k++) begin
            len = $urandom_range(12, 1);
            wr = 1'($urandom_range(1, 0));
            base = (k == 3) ? 32'hFFFF_FFF0 : $urandom;
            rmask = $urandom;
            run_cmd(base, len, wr, tmo);
            n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_timeout: got %b want 0", k, tmo); end
            n_checks++; if (alog.size() !== len) begin n_fail++; $display("FAIL rnd%0d_beats: got %0d want %0d", k, alog.size(), len); end
            foreach (alog[i]) begin
                e = {base[31:2], 2'b00} + 32'(4 * i);
                n_checks++; if (alog[i] !== e) begin n_fail++; $display("FAIL rnd%0d_addr[%0d]: got %h want %h", k, i, alog[i], e); end
            end
            if (wr) begin
                n_checks++; if (wlog.size() !== len) begin n_fail++; $display("FAIL rnd%0d_words: got %0d want %0d", k, wlog.size(), len); end
                foreach (wlog[i]) begin
                    n_checks++; if (wlog[i] !== exp_w[i]) begin n_fail++; $display("FAIL rnd%0d_wdata[%0d]: got %h want %h", k, i, wlog[i], exp_w[i]); end
                end
            end else begin
                n_checks++; if (rlog.size() !== len) begin n_fail++; $display("FAIL rnd%0d_reads: got %0d want %0d", k, rlog.size(), len); end
                foreach (rlog[i]) begin
                    e = ({base[31:2], 2'b00} + 32'(4 * i)) ^ rmask;
                    n_checks++; if (rlog[i] !== e) begin n_fail++; $display("FAIL rnd%0d_rdata[%0d]: got %h want %h", k, i, rlog[i], e); end
                end
            end
            n_checks++; if (done_log.size() !== 1 || err_log.size() !== 0) begin
                n_fail++; $display("FAIL rnd%0d_status: got done=%0d err=%0d want 1/0", k, done_log.size(), err_log.size()); end
            n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL rnd%0d_protocol: got %0d violations want 0", k, viol); end
        end
        wait_pct = 0; gap_pct = 0;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_stall_gaps();
        test_error();
        test_zero_len_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
